param_accumulator: RTL and testbench
====================================

# param_accumulator

Parametrised successor to the 8-bit switch-driven accumulator datapath. It has a WIDTH-bit registered operand stage feeding a ripple-carry adder/subtractor and a WIDTH-bit accumulator register. It adds subtract, load and clear operations, signed-overflow detection with optional saturation, a sticky overflow flag and a completed-operation counter. It sits between board I/O (switch sampling, keys) and the hex7seg display drivers, which consume Acc and B.

## Interface
- WIDTH, 8: datapath width in bits (≥2).
- SATURATE, 0: when 1, signed overflow clamps Acc; when 0, Acc wraps modulo 2^WIDTH.
- CNT_WIDTH, 8: width of the operation counter.
- Clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately.
- en  input  1  capture D and op into the operand stage this edge.
- op  input  2  operation: 00 add, 01 sub, 10 load, 11 clear.
- D  input  WIDTH  operand data.
- Acc  output  WIDTH  accumulator register.
- B  output  WIDTH  operand register (last captured D).
- Cout  output  1  carry out of the last add/sub. For sub, 1 means no borrow.
- Ovf  output  1  signed overflow of the last completed op.
- Sticky  output  1  set by any Ovf; cleared only by the clear op or reset.
- Count  output  CNT_WIDTH  number of completed add/sub/load ops, wraps.
- Done  output  1  one-cycle pulse, high in the cycle after Acc was updated.

## Operation
- Reset values: Acc=0, B=0, Cout=0, Ovf=0, Sticky=0, Count=0, Done=0. The internal stage-valid bit v and op_r are also 0.
- Stage 1, every edge:
  - If en=1: B←D, op_r←op, v←1.
  - Otherwise v←0. B and op_r hold.
- Stage 2, on an edge with v=1, executes op_r on Acc and B and sets Done←1. With v=0, Done←0 and Acc and all flags hold.
- add: {c,s} = Acc + B + 0 through a WIDTH-bit ripple-carry chain of full adders. Acc←s, Cout←c.
- sub: same chain using ~B with carry-in 1. Acc←s, Cout←c.
- Signed overflow:
  - ovf = (Acc[MSB] == Bx[MSB]) && (s[MSB] != Acc[MSB]).
  - Bx is B for add and ~B for sub.
  - Ovf←ovf; Sticky←Sticky|ovf.
- SATURATE=1 with ovf=1: Acc←0111…1 if Acc[MSB]=0, else 1000…0. Cout is still the raw carry.
- load: Acc←B, Cout←0, Ovf←0, Sticky holds.
- Count: add, sub and load each increment Count by 1 modulo 2^CNT_WIDTH.
- clear: Acc←0, Cout←0, Ovf←0, Sticky←0, Count←0. Clear is not counted.
- No hazards: stage 2 is the only reader and writer of Acc, so back-to-back ops chain correctly with one op per cycle.

## Timing
- Latency: D sampled at edge n (en=1), Acc/flags/Count updated at edge n+1, Done high during cycle n+1→n+2.
- Throughput: one op per clock. With en held high, Done stays high continuously.
- en=0 bubbles: no update, Done=0, B holds.
- Reset mid-operation: reset low at any time clears everything asynchronously, including a captured but unexecuted operand (v=0). The first edge after release does nothing unless en=1 at that edge.
- Reset has priority over every other input. Outputs are registered with no combinational path from inputs to outputs.

## Test plan
- Reset: drive reset=0 mid-stream with Acc=0x3C → all outputs 0 immediately. After release with en=0 for 3 cycles → Acc=0, Done=0.
- Back-to-back add (WIDTH=8): en=1 with add 0x05 then add 0x03 on consecutive edges → Acc=0x05 at edge 2, 0x08 at edge 3, Count=2, Done high 2 cycles.
- Signed overflow: load 0x7F, add 0x01 →
  - SATURATE=0: Acc=0x80, Ovf=1, Sticky=1, Cout=0.
  - SATURATE=1: Acc=0x7F, Ovf=1.
  - A following add 0x00 leaves Ovf=0 and Sticky=1.
- Subtract and borrow: load 0x10, sub 0x20 → Acc=0xF0, Cout=0, Ovf=0. Then sub 0x70 → Acc=0x80, Cout=1, Ovf=0.
- Unsigned carry: load 0x01, add 0xFF → Acc=0x00, Cout=1, Ovf=0. Then clear → Acc=0, Sticky=0, Count=0.
- Counter wrap and bubbles (CNT_WIDTH=2): 4 adds interleaved with en=0 cycles → Count sequence 1,2,3,0. Done pulses only on the 4 executing cycles.

Source files
------------

// File: rtl/param_accumulator_if.sv
// Operand/result bundle between board I/O and the accumulator datapath.
// The master drives the operation request. The slave returns the registered results.
interface param_accumulator_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
);
    logic                 en;
    logic [1:0]           op;
    logic [WIDTH-1:0]     D;
    logic [WIDTH-1:0]     Acc;
    logic [WIDTH-1:0]     B;
    logic                 Cout;
    logic                 Ovf;
    logic                 Sticky;
    logic [CNT_WIDTH-1:0] Count;
    logic                 Done;

    modport master (
        output en, op, D,
        input  Acc, B, Cout, Ovf, Sticky, Count, Done
    );

    modport slave (
        input  en, op, D,
        output Acc, B, Cout, Ovf, Sticky, Count, Done
    );
endinterface

// File: rtl/param_accumulator.sv
// Two-stage accumulator: registered operand stage, then a ripple-carry add/sub/load/clear
// stage with signed-overflow detection, optional saturation, sticky flag and op counter.
module param_accumulator #(
    parameter int WIDTH     = 8,
    parameter bit SATURATE  = 1'b0,
    parameter int CNT_WIDTH = 8
) (
    input  logic              Clk,
    input  logic              reset,
    param_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]     b_q, b_d, acc_q, acc_d;
    op_e                  op_q, op_d;
    logic                 v_q, v_d;
    logic                 cout_q, cout_d, ovf_q, ovf_d, sticky_q, sticky_d, done_q, done_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic [WIDTH-1:0]     bx, sum;
    logic [WIDTH:0]       carry;
    logic                 is_sub, ovf;

    // Subtraction reuses the adder as Acc + ~B + 1.
    assign is_sub   = (op_q == OP_SUB);
    assign bx       = is_sub ? ~b_q : b_q;
    assign carry[0] = is_sub;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign sum[gi]      = acc_q[gi] ^ bx[gi] ^ carry[gi];
            assign carry[gi+1]  = (acc_q[gi] & bx[gi]) | (carry[gi] & (acc_q[gi] ^ bx[gi]));
        end
    endgenerate

    assign ovf = (acc_q[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);

    always_comb begin
        b_d      = bus.en ? bus.D : b_q;
        op_d     = bus.en ? op_e'(bus.op) : op_q;
        v_d      = bus.en;
        acc_d    = acc_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        count_d  = count_q;
        done_d   = v_q;

        if (v_q) begin
            case (op_q)
                OP_ADD, OP_SUB: begin
                    acc_d    = sum;
                    cout_d   = carry[WIDTH];
                    ovf_d    = ovf;
                    sticky_d = sticky_q | ovf;
                    count_d  = count_q + CNT_WIDTH'(1);
                    // Overflow direction follows the sign of the old Acc.
                    if (SATURATE && ovf) begin
                        acc_d = acc_q[WIDTH-1] ? SAT_NEG : SAT_POS;
                    end
                end
                OP_LOAD: begin
                    acc_d   = b_q;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    count_d = count_q + CNT_WIDTH'(1);
                end
                OP_CLEAR: begin
                    acc_d    = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    sticky_d = 1'b0;
                    count_d  = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            b_q      <= '0;
            op_q     <= OP_ADD;
            v_q      <= 1'b0;
            acc_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            b_q      <= b_d;
            op_q     <= op_d;
            v_q      <= v_d;
            acc_q    <= acc_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    assign bus.Acc    = acc_q;
    assign bus.B      = b_q;
    assign bus.Cout   = cout_q;
    assign bus.Ovf    = ovf_q;
    assign bus.Sticky = sticky_q;
    assign bus.Count  = count_q;
    assign bus.Done   = done_q;
endmodule

// File: tb/tb_param_accumulator.sv
// Bench for param_accumulator: a wrapping instance (CNT_WIDTH=2) and a saturating instance
// (CNT_WIDTH=8) share one stimulus stream and are checked against an arithmetic model.
module tb_param_accumulator;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] d = 8'h00;
    int         checks = 0;
    int         failures = 0;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    param_accumulator_if #(.WIDTH(8), .CNT_WIDTH(2)) if0 ();
    param_accumulator_if #(.WIDTH(8), .CNT_WIDTH(8)) if1 ();

    assign if0.en = en;
    assign if0.op = op;
    assign if0.D  = d;
    assign if1.en = en;
    assign if1.op = op;
    assign if1.D  = d;

    param_accumulator #(.WIDTH(8), .SATURATE(1'b0), .CNT_WIDTH(2)) u_dut0 (
        .Clk(clk), .reset(rst_n), .bus(if0));
    param_accumulator #(.WIDTH(8), .SATURATE(1'b1), .CNT_WIDTH(8)) u_dut1 (
        .Clk(clk), .reset(rst_n), .bus(if1));

    logic [7:0] o_acc[2], o_b[2], o_cnt[2];
    logic       o_cout[2], o_ovf[2], o_sticky[2], o_done[2];
    assign o_acc[0] = if0.Acc;   assign o_acc[1] = if1.Acc;
    assign o_b[0]   = if0.B;     assign o_b[1]   = if1.B;
    assign o_cnt[0] = {6'b0, if0.Count};
    assign o_cnt[1] = if1.Count;
    assign o_cout[0] = if0.Cout;     assign o_cout[1] = if1.Cout;
    assign o_ovf[0] = if0.Ovf;       assign o_ovf[1] = if1.Ovf;
    assign o_sticky[0] = if0.Sticky; assign o_sticky[1] = if1.Sticky;
    assign o_done[0] = if0.Done;     assign o_done[1] = if1.Done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Model: instance 0 wraps with a 2-bit count, instance 1 saturates with an 8-bit count.
    logic [7:0] m_acc[2];
    logic       m_cout[2], m_ovf[2], m_sticky[2], m_done[2];
    int         m_cnt[2];
    logic [7:0] m_b;
    logic [1:0] m_op;
    logic       m_v;

    task automatic model_exec(input int i);
        int sa, sb, sr, ua, ub, res;
        bit ov;
        sa = $signed(m_acc[i]);
        sb = $signed(m_b);
        ua = m_acc[i];
        ub = m_b;
        res = 0;
        sr = 0;
        case (m_op)
            ADD, SUB: begin
                if (m_op == ADD) begin
                    sr = sa + sb;
                    m_cout[i] = (ua + ub) > 255;
                    res = (ua + ub) & 255;
                end else begin
                    sr = sa - sb;
                    m_cout[i] = (ua >= ub);
                    res = (ua - ub) & 255;
                end
                ov = (sr > 127) || (sr < -128);
                if (ov && i == 1) res = (sr > 127) ? 127 : 128;
                m_acc[i] = 8'(res);
                m_ovf[i] = ov;
                m_sticky[i] = m_sticky[i] | ov;
                m_cnt[i] = (m_cnt[i] + 1) & ((i == 0) ? 3 : 255);
            end
            LOAD: begin
                m_acc[i] = m_b;
                m_cout[i] = 1'b0;
                m_ovf[i] = 1'b0;
                m_cnt[i] = (m_cnt[i] + 1) & ((i == 0) ? 3 : 255);
            end
            default: begin
                m_acc[i] = 8'h00;
                m_cout[i] = 1'b0;
                m_ovf[i] = 1'b0;
                m_sticky[i] = 1'b0;
                m_cnt[i] = 0;
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_b = 8'h00; m_op = 2'b00; m_v = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    m_acc[i] = 8'h00; m_cout[i] = 1'b0; m_ovf[i] = 1'b0;
                    m_sticky[i] = 1'b0; m_done[i] = 1'b0; m_cnt[i] = 0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    m_done[i] = m_v;
                    if (m_v) model_exec(i);
                end
                m_v = en;
                if (en) begin
                    m_b = d;
                    m_op = op;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("u%0d_acc", i), o_acc[i], m_acc[i]);
                    chk($sformatf("u%0d_b", i), o_b[i], m_b);
                    chk($sformatf("u%0d_cout", i), o_cout[i], m_cout[i]);
                    chk($sformatf("u%0d_ovf", i), o_ovf[i], m_ovf[i]);
                    chk($sformatf("u%0d_sticky", i), o_sticky[i], m_sticky[i]);
                    chk($sformatf("u%0d_count", i), o_cnt[i], m_cnt[i]);
                    chk($sformatf("u%0d_done", i), o_done[i], m_done[i]);
                end
            end
        end
    end

    task automatic step(input logic e, input logic [1:0] o, input logic [7:0] dd);
        en = e;
        op = o;
        d = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_u%0d_outs", tag, i),
                {o_acc[i], o_b[i], o_cnt[i], o_cout[i], o_ovf[i], o_sticky[i], o_done[i]}, 0);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_all_zero("por");
        #10 rst_n = 1'b1;
        chk_en = 1'b1;

        // Back-to-back adds
        step(1'b1, ADD, 8'h05);
        step(1'b1, ADD, 8'h03);
        chk("b2b_acc1", if0.Acc, 8'h05);
        chk("b2b_done1", if0.Done, 1);
        step(1'b0, ADD, 8'h00);
        chk("b2b_acc2", if0.Acc, 8'h08);
        chk("b2b_cnt", if0.Count, 2);
        chk("b2b_done2", if0.Done, 1);
        step(1'b0, ADD, 8'h00);
        chk("b2b_done3", if0.Done, 0);
        $display("b2b add: acc=%0h count=%0d", if0.Acc, if0.Count);

        // Signed overflow, wrap vs saturate
        step(1'b1, CLR, 8'h00);
        step(1'b1, LOAD, 8'h7F);
        step(1'b1, ADD, 8'h01);
        step(1'b1, ADD, 8'h00);
        chk("ovf_wrap_acc", if0.Acc, 8'h80);
        chk("ovf_wrap_flags", {if0.Ovf, if0.Sticky, if0.Cout}, 3'b110);
        chk("ovf_sat_acc", if1.Acc, 8'h7F);
        chk("ovf_sat_ovf", if1.Ovf, 1);
        step(1'b0, ADD, 8'h00);
        chk("ovf_after", {if0.Ovf, if0.Sticky}, 2'b01);
        $display("overflow: wrap acc=%0h sat acc=%0h", if0.Acc, if1.Acc);

        // Subtract and borrow
        step(1'b1, LOAD, 8'h10);
        step(1'b1, SUB, 8'h20);
        step(1'b1, SUB, 8'h70);
        chk("sub1", {if0.Acc, if0.Cout, if0.Ovf}, {8'hF0, 1'b0, 1'b0});
        step(1'b0, ADD, 8'h00);
        chk("sub2", {if0.Acc, if0.Cout, if0.Ovf}, {8'h80, 1'b1, 1'b0});
        $display("subtract: acc=%0h cout=%0b", if0.Acc, if0.Cout);

        // Unsigned carry then clear
        step(1'b1, LOAD, 8'h01);
        step(1'b1, ADD, 8'hFF);
        step(1'b1, CLR, 8'h00);
        chk("carry", {if0.Acc, if0.Cout, if0.Ovf}, {8'h00, 1'b1, 1'b0});
        step(1'b0, ADD, 8'h00);
        chk("clear", {if0.Acc, if0.Sticky, 6'b0, if0.Count}, 16'h0000);
        chk("clear_cnt8", if1.Count, 0);
        $display("carry/clear: acc=%0h count=%0d", if0.Acc, if0.Count);

        // Counter wrap with bubbles
        for (int k = 0; k < 4; k++) begin
            step(1'b1, ADD, 8'(k + 1));
            chk("wrap_bubble_done", if0.Done, 0);
            step(1'b0, ADD, 8'h00);
            chk("wrap_cnt", if0.Count, (k + 1) % 4);
            chk("wrap_done", if0.Done, 1);
            $display("wrap add %0d: count=%0d", k + 1, if0.Count);
        end
        chk("wrap_cnt8", if1.Count, 4);

        // Reset mid-operation with a captured operand pending
        step(1'b1, LOAD, 8'h3C);
        step(1'b1, ADD, 8'h05);
        chk("pre_rst_acc", if0.Acc, 8'h3C);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst");
        #3 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, ADD, 8'h00);
            chk("post_rst", {if0.Acc, if0.Done}, 9'h000);
        end
        $display("reset mid-op: acc=%0h done=%0b", if0.Acc, if0.Done);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
